// File: rtl/cascade_pkg.sv
// Shared constants for the cascade detector: anomaly codes, the reset-time
// pattern table and the layout of one history entry.
package cascade_pkg;

    localparam int NONE  = 0;
    localparam int SPIKE = 1;
    localparam int VOL   = 2;
    localparam int FLASH = 3;
    localparam int STUFF = 5;

    localparam int HE_CODE_W = 3;
    localparam int HE_AGE_W  = 8;

    typedef struct packed {
        logic [HE_CODE_W-1:0] code;
        logic [HE_AGE_W-1:0]  age;
        logic                 live;
    } hist_entry_t;

    localparam int DEF_NUM_PAT = 4;
    localparam int DEF_TRIGGER = FLASH;

    function automatic logic def_en(input int p);
        return (p < DEF_NUM_PAT);
    endfunction

    function automatic logic [7:0] def_mask(input int p);
        case (p)
            0:       return 8'(1 << VOL);
            1:       return 8'(1 << SPIKE);
            2:       return 8'(1 << STUFF);
            3:       return 8'((1 << SPIKE) | (1 << VOL) | (1 << STUFF));
            default: return 8'd0;
        endcase
    endfunction

    function automatic int def_min(input int p);
        case (p)
            0, 1, 2: return 1;
            3:       return 2;
            default: return 0;
        endcase
    endfunction

endpackage

// File: rtl/cascade_hist_slot.sv
// One history entry: code, saturating age and live bit, with shift-load and flush.
module cascade_hist_slot
    import cascade_pkg::*;
#(
    parameter int WINDOW = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_flush,
    input  logic                 i_load,
    input  logic [HE_CODE_W-1:0] i_code,
    input  logic [HE_AGE_W-1:0]  i_age,
    input  logic                 i_live,
    output logic                 o_live,
    output logic [HE_CODE_W-1:0] o_aged_code,
    output logic [HE_AGE_W-1:0]  o_aged_age,
    output logic                 o_aged_live
);

    localparam logic [HE_AGE_W-1:0] WIN = HE_AGE_W'(WINDOW);

    hist_entry_t r_entry;
    hist_entry_t w_aged;

    // The aged view is what this entry looks like once the current cycle's
    // ageing is applied; matching and shifting both use it.
    always_comb begin
        w_aged = r_entry;
        if (r_entry.live) begin
            w_aged.age  = (r_entry.age >= WIN) ? WIN : r_entry.age + HE_AGE_W'(1);
            w_aged.live = (w_aged.age < WIN);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_entry <= '0;
        end else if (i_flush) begin
            r_entry.age  <= '0;
            r_entry.live <= 1'b0;
        end else if (i_load) begin
            r_entry.code <= i_code;
            r_entry.age  <= i_age;
            r_entry.live <= i_live;
        end else begin
            r_entry <= w_aged;
        end
    end

    assign o_live      = r_entry.live;
    assign o_aged_code = w_aged.code;
    assign o_aged_age  = w_aged.age;
    assign o_aged_live = w_aged.live;

endmodule

// File: rtl/cascade_engine.sv
// Multi-source cascade detector: arbitrates anomaly events, keeps an ageing
// history and raises a held alert plus a breaker override on a pattern match.
module cascade_engine
    import cascade_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int CODE_W     = 3,
    parameter int HIST_DEPTH = 4,
    parameter int WINDOW     = 64,
    parameter int HOLD       = 32,
    parameter int NUM_PAT    = 4,
    parameter int CONF_SHIFT = 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              flush,
    input  logic [NUM_SRC-1:0]                src_valid,
    input  logic [NUM_SRC*CODE_W-1:0]         src_code,
    input  logic [NUM_SRC*8-1:0]              src_conf,
    input  logic                              cfg_we,
    input  logic [$clog2(NUM_PAT)-1:0]        cfg_idx,
    input  logic                              cfg_en,
    input  logic [CODE_W-1:0]                 cfg_trigger,
    input  logic [2**CODE_W-1:0]              cfg_pre_mask,
    input  logic [$clog2(HIST_DEPTH+1)-1:0]   cfg_min_pre,
    output logic                              cascade_alert,
    output logic [$clog2(NUM_PAT)-1:0]        cascade_type,
    output logic                              cascade_cb_load,
    output logic [7:0]                        cascade_cb_param,
    output logic [7:0]                        drop_cnt,
    output logic [$clog2(HIST_DEPTH+1)-1:0]   hist_occ
);

    localparam int IDX_W  = $clog2(NUM_PAT);
    localparam int CNT_W  = $clog2(HIST_DEPTH+1);
    localparam int MASK_W = 2**CODE_W;
    localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int SH_W   = 8 + CONF_SHIFT;

    logic               w_sel_valid;
    logic [CODE_W-1:0]  w_sel_code;
    logic [7:0]         w_sel_conf;
    logic [7:0]         w_num_drop;
    logic               w_evt;

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_code  = '0;
        w_sel_conf  = '0;
        w_num_drop  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i] && (src_code[i*CODE_W +: CODE_W] != '0)) begin
                if (w_sel_valid) begin
                    w_num_drop = w_num_drop + 8'd1;
                end else begin
                    w_sel_valid = 1'b1;
                    w_sel_code  = src_code[i*CODE_W +: CODE_W];
                    w_sel_conf  = src_conf[i*8 +: 8];
                end
            end
        end
    end

    // A flush swallows the whole cycle's traffic, including drops.
    assign w_evt = w_sel_valid && !flush;

    logic [HIST_DEPTH-1:0] w_live_q;
    logic [HIST_DEPTH-1:0] w_aged_live;
    logic [HIST_DEPTH-1:0] w_in_live;
    logic [CODE_W-1:0]     w_aged_code [HIST_DEPTH];
    logic [HE_AGE_W-1:0]   w_aged_age  [HIST_DEPTH];
    logic [CODE_W-1:0]     w_in_code   [HIST_DEPTH];
    logic [HE_AGE_W-1:0]   w_in_age    [HIST_DEPTH];

    for (genvar k = 0; k < HIST_DEPTH; k++) begin : g_hist
        if (k == 0) begin : g_head
            assign w_in_code[k] = w_sel_code;
            assign w_in_age[k]  = '0;
            assign w_in_live[k] = 1'b1;
        end else begin : g_tail
            assign w_in_code[k] = w_aged_code[k-1];
            assign w_in_age[k]  = w_aged_age[k-1];
            assign w_in_live[k] = w_aged_live[k-1];
        end

        cascade_hist_slot #(.WINDOW(WINDOW)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_flush     (flush),
            .i_load      (w_evt),
            .i_code      (w_in_code[k]),
            .i_age       (w_in_age[k]),
            .i_live      (w_in_live[k]),
            .o_live      (w_live_q[k]),
            .o_aged_code (w_aged_code[k]),
            .o_aged_age  (w_aged_age[k]),
            .o_aged_live (w_aged_live[k])
        );
    end

    logic              r_pat_en   [NUM_PAT];
    logic [CODE_W-1:0] r_pat_trig [NUM_PAT];
    logic [MASK_W-1:0] r_pat_mask [NUM_PAT];
    logic [CNT_W-1:0]  r_pat_min  [NUM_PAT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PAT; p++) begin
                r_pat_en[p]   <= def_en(p);
                r_pat_trig[p] <= CODE_W'(DEF_TRIGGER);
                r_pat_mask[p] <= MASK_W'(def_mask(p));
                r_pat_min[p]  <= CNT_W'(def_min(p));
            end
        end else if (cfg_we) begin
            r_pat_en[cfg_idx]   <= cfg_en;
            r_pat_trig[cfg_idx] <= cfg_trigger;
            r_pat_mask[cfg_idx] <= cfg_pre_mask;
            r_pat_min[cfg_idx]  <= cfg_min_pre;
        end
    end

    logic             w_fire;
    logic [IDX_W-1:0] w_fire_idx;

    // Later patterns overwrite earlier hits, so the highest index wins.
    always_comb begin
        logic [CNT_W-1:0] v_cnt;
        w_fire     = 1'b0;
        w_fire_idx = '0;
        v_cnt      = '0;
        for (int p = 0; p < NUM_PAT; p++) begin
            v_cnt = '0;
            for (int k = 0; k < HIST_DEPTH; k++) begin
                if (w_aged_live[k] && r_pat_mask[p][w_aged_code[k]])
                    v_cnt = v_cnt + CNT_W'(1);
            end
            if (w_evt && r_pat_en[p] && (r_pat_trig[p] == w_sel_code) &&
                (r_pat_min[p] != '0) && (v_cnt >= r_pat_min[p])) begin
                w_fire     = 1'b1;
                w_fire_idx = IDX_W'(p);
            end
        end
    end

    logic [SH_W-1:0] w_shifted;
    logic [7:0]      w_param;
    logic [8:0]      w_drop_sum;

    assign w_shifted  = SH_W'(w_sel_conf) << CONF_SHIFT;
    assign w_param    = (|w_shifted[SH_W-1:8]) ? 8'hFF : w_shifted[7:0];
    assign w_drop_sum = {1'b0, drop_cnt} + {1'b0, (flush ? 8'd0 : w_num_drop)};

    logic              r_alert;
    logic [IDX_W-1:0]  r_type;
    logic              r_cb_load;
    logic [7:0]        r_cb_param;
    logic [7:0]        r_drop;
    logic [HOLD_W-1:0] r_hold;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alert    <= 1'b0;
            r_type     <= '0;
            r_cb_load  <= 1'b0;
            r_cb_param <= '0;
            r_drop     <= '0;
            r_hold     <= '0;
        end else begin
            r_cb_load <= w_fire;
            r_drop    <= w_drop_sum[8] ? 8'hFF : w_drop_sum[7:0];
            if (w_fire) begin
                r_alert    <= 1'b1;
                r_type     <= w_fire_idx;
                r_cb_param <= w_param;
                r_hold     <= HOLD_W'(HOLD - 1);
            end else if (r_alert) begin
                if (r_hold == '0) r_alert <= 1'b0;
                else              r_hold  <= r_hold - HOLD_W'(1);
            end
        end
    end

    logic [CNT_W-1:0] w_occ;

    always_comb begin
        w_occ = '0;
        for (int k = 0; k < HIST_DEPTH; k++) w_occ = w_occ + CNT_W'(w_live_q[k]);
    end

    assign cascade_alert    = r_alert;
    assign cascade_type     = r_type;
    assign cascade_cb_load  = r_cb_load;
    assign cascade_cb_param = r_cb_param;
    assign drop_cnt         = r_drop;
    assign hist_occ         = w_occ;

endmodule

// File: tb/tb_cascade_engine.sv
// Directed bench for cascade_engine: arbitration, ageing window, pattern
// matching, hold behaviour, table programming, flush and reset.
module tb_cascade_engine;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [1:0]  src_valid;
    logic [5:0]  src_code;
    logic [15:0] src_conf;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [2:0]  cfg_trigger;
    logic [7:0]  cfg_pre_mask;
    logic [2:0]  cfg_min_pre;
    logic        cascade_alert;
    logic [1:0]  cascade_type;
    logic        cascade_cb_load;
    logic [7:0]  cascade_cb_param;
    logic [7:0]  drop_cnt;
    logic [2:0]  hist_occ;

    int checks = 0;
    int errors = 0;

    cascade_engine dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .flush            (flush),
        .src_valid        (src_valid),
        .src_code         (src_code),
        .src_conf         (src_conf),
        .cfg_we           (cfg_we),
        .cfg_idx          (cfg_idx),
        .cfg_en           (cfg_en),
        .cfg_trigger      (cfg_trigger),
        .cfg_pre_mask     (cfg_pre_mask),
        .cfg_min_pre      (cfg_min_pre),
        .cascade_alert    (cascade_alert),
        .cascade_type     (cascade_type),
        .cascade_cb_load  (cascade_cb_load),
        .cascade_cb_param (cascade_cb_param),
        .drop_cnt         (drop_cnt),
        .hist_occ         (hist_occ)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [2:0] code, input logic [7:0] conf);
        src_valid = 2'b01;
        src_code  = {3'd0, code};
        src_conf  = {8'h00, conf};
        tick();
        src_valid = '0;
        src_code  = '0;
        src_conf  = '0;
    endtask

    task automatic send_both(input logic [2:0] c0, input logic [2:0] c1);
        src_valid = 2'b11;
        src_code  = {c1, c0};
        src_conf  = 16'h1010;
        tick();
        src_valid = '0;
        src_code  = '0;
        src_conf  = '0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic settle();
        do_flush();
        idle(40);
    endtask

    task automatic cfg_write(input logic [1:0] idx, input logic en, input logic [2:0] trig,
                             input logic [7:0] mask, input logic [2:0] min_pre);
        cfg_we = 1'b1; cfg_idx = idx; cfg_en = en; cfg_trigger = trig;
        cfg_pre_mask = mask; cfg_min_pre = min_pre;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; src_valid = '0; src_code = '0; src_conf = '0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_trigger = '0; cfg_pre_mask = '0; cfg_min_pre = '0;
        #12;
        checks++; if (cascade_alert !== 1'b0) begin errors++; $display("FAIL reset_alert got %b want 0", cascade_alert); end
        checks++; if (cascade_type !== 2'd0) begin errors++; $display("FAIL reset_type got %0d want 0", cascade_type); end
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL reset_cb_load got %b want 0", cascade_cb_load); end
        checks++; if (cascade_cb_param !== 8'h00) begin errors++; $display("FAIL reset_cb_param got %h want 00", cascade_cb_param); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
        checks++; if (hist_occ !== 3'd0) begin errors++; $display("FAIL reset_occ got %0d want 0", hist_occ); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);
        checks++; if (hist_occ !== 3'd0) begin errors++; $display("FAIL post_reset_occ got %0d want 0", hist_occ); end
    endtask

    task automatic test_basic_fire();
        int n;
        settle();
        send(3'd2, 8'h40);
        idle(4);
        send(3'd3, 8'h40);
        checks++; if (cascade_cb_load !== 1'b1) begin errors++; $display("FAIL basic_cb_load got %b want 1", cascade_cb_load); end
        checks++; if (cascade_type !== 2'd0) begin errors++; $display("FAIL basic_type got %0d want 0", cascade_type); end
        checks++; if (cascade_cb_param !== 8'h80) begin errors++; $display("FAIL basic_param got %h want 80", cascade_cb_param); end
        checks++; if (hist_occ !== 3'd2) begin errors++; $display("FAIL basic_occ got %0d want 2", hist_occ); end
        n = cascade_alert ? 1 : 0;
        tick();
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL basic_pulse got %b want 0", cascade_cb_load); end
        checks++; if (cascade_cb_param !== 8'h80) begin errors++; $display("FAIL basic_param_hold got %h want 80", cascade_cb_param); end
        repeat (39) begin
            if (cascade_alert) n++;
            tick();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL basic_hold_len got %0d want 32", n); end
    endtask

    task automatic test_multi_pattern();
        settle();
        send(3'd1, 8'h00);
        idle(2);
        send(3'd2, 8'h00);
        send(3'd3, 8'h90);
        checks++; if (cascade_type !== 2'd3) begin errors++; $display("FAIL multi_type got %0d want 3", cascade_type); end
        checks++; if (cascade_cb_param !== 8'hFF) begin errors++; $display("FAIL multi_param_sat got %h want ff", cascade_cb_param); end
        settle();
        send(3'd1, 8'h00);
        idle(2);
        send(3'd2, 8'h00);
        send(3'd3, 8'h30);
        checks++; if (cascade_cb_load !== 1'b1) begin errors++; $display("FAIL multi_cb_load got %b want 1", cascade_cb_load); end
        checks++; if (cascade_cb_param !== 8'h60) begin errors++; $display("FAIL multi_param got %h want 60", cascade_cb_param); end
    endtask

    task automatic test_window();
        settle();
        send(3'd2, 8'h10);
        idle(63);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL window_expired_load got %b want 0", cascade_cb_load); end
        checks++; if (hist_occ !== 3'd1) begin errors++; $display("FAIL window_expired_occ got %0d want 1", hist_occ); end
        settle();
        send(3'd2, 8'h10);
        idle(62);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b1) begin errors++; $display("FAIL window_edge_load got %b want 1", cascade_cb_load); end
        checks++; if (hist_occ !== 3'd2) begin errors++; $display("FAIL window_edge_occ got %0d want 2", hist_occ); end
    endtask

    task automatic test_flush_trigger();
        settle();
        send(3'd2, 8'h10);
        flush = 1'b1;
        send_both(3'd3, 3'd5);
        flush = 1'b0;
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL flush_cb_load got %b want 0", cascade_cb_load); end
        checks++; if (hist_occ !== 3'd0) begin errors++; $display("FAIL flush_occ got %0d want 0", hist_occ); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL flush_drop got %0d want 0", drop_cnt); end
        checks++; if (cascade_alert !== 1'b0) begin errors++; $display("FAIL flush_alert got %b want 0", cascade_alert); end
    endtask

    task automatic test_drop();
        settle();
        send_both(3'd2, 3'd5);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_one got %0d want 1", drop_cnt); end
        checks++; if (hist_occ !== 3'd1) begin errors++; $display("FAIL drop_occ got %0d want 1", hist_occ); end
        send(3'd3, 8'h10);
        checks++; if (cascade_type !== 2'd0) begin errors++; $display("FAIL drop_winner_type got %0d want 0", cascade_type); end
        send_both(3'd0, 3'd1);
        checks++; if (drop_cnt !== 8'd1) begin errors++; $display("FAIL drop_src1_only got %0d want 1", drop_cnt); end
        send(3'd3, 8'h10);
        checks++; if (cascade_type !== 2'd3) begin errors++; $display("FAIL drop_src1_type got %0d want 3", cascade_type); end
        repeat (300) send_both(3'd2, 3'd5);
        checks++; if (drop_cnt !== 8'd255) begin errors++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
    endtask

    task automatic test_cfg();
        settle();
        cfg_write(2'd1, 1'b0, 3'd3, 8'b0000_0010, 3'd1);
        send(3'd1, 8'h10);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL cfg_disabled_load got %b want 0", cascade_cb_load); end
        checks++; if (cascade_alert !== 1'b0) begin errors++; $display("FAIL cfg_disabled_alert got %b want 0", cascade_alert); end
        settle();
        cfg_write(2'd1, 1'b1, 3'd3, 8'b0000_0010, 3'd1);
        send(3'd1, 8'h10);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b1) begin errors++; $display("FAIL cfg_enabled_load got %b want 1", cascade_cb_load); end
        checks++; if (cascade_type !== 2'd1) begin errors++; $display("FAIL cfg_enabled_type got %0d want 1", cascade_type); end
        settle();
        cfg_write(2'd1, 1'b1, 3'd3, 8'b0000_0010, 3'd0);
        send(3'd1, 8'h10);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL cfg_min_zero got %b want 0", cascade_cb_load); end
        settle();
        cfg_write(2'd1, 1'b1, 3'd3, 8'b0000_0010, 3'd1);
        send(3'd1, 8'h10);
        cfg_we = 1'b1; cfg_idx = 2'd1; cfg_en = 1'b0; cfg_trigger = 3'd3; cfg_pre_mask = 8'b0000_0010; cfg_min_pre = 3'd1;
        send(3'd3, 8'h10);
        cfg_we = 1'b0;
        checks++; if (cascade_type !== 2'd1 || cascade_cb_load !== 1'b1) begin errors++; $display("FAIL cfg_same_cycle got type %0d load %b want 1 1", cascade_type, cascade_cb_load); end
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b0) begin errors++; $display("FAIL cfg_after_write got %b want 0", cascade_cb_load); end
        cfg_write(2'd1, 1'b1, 3'd3, 8'b0000_0010, 3'd1);
    endtask

    task automatic test_back_to_back();
        int n;
        settle();
        send(3'd1, 8'h10);
        send(3'd3, 8'h10);
        checks++; if (cascade_type !== 2'd1) begin errors++; $display("FAIL b2b_first_type got %0d want 1", cascade_type); end
        idle(17);
        send(3'd5, 8'h10);
        checks++; if (cascade_alert !== 1'b1 || cascade_cb_load !== 1'b0) begin errors++; $display("FAIL b2b_mid_hold got alert %b load %b want 1 0", cascade_alert, cascade_cb_load); end
        send(3'd3, 8'h20);
        checks++; if (cascade_cb_load !== 1'b1) begin errors++; $display("FAIL b2b_second_load got %b want 1", cascade_cb_load); end
        checks++; if (cascade_type !== 2'd3) begin errors++; $display("FAIL b2b_second_type got %0d want 3", cascade_type); end
        checks++; if (cascade_cb_param !== 8'h40) begin errors++; $display("FAIL b2b_second_param got %h want 40", cascade_cb_param); end
        n = cascade_alert ? 1 : 0;
        tick();
        repeat (39) begin
            if (cascade_alert) n++;
            tick();
        end
        checks++; if (n != 32) begin errors++; $display("FAIL b2b_hold_len got %0d want 32", n); end
    endtask

    task automatic test_reset_mid_hold();
        settle();
        cfg_write(2'd0, 1'b0, 3'd3, 8'b0000_0100, 3'd1);
        send(3'd1, 8'h10);
        send(3'd3, 8'h10);
        idle(5);
        checks++; if (cascade_alert !== 1'b1) begin errors++; $display("FAIL rst_pre_alert got %b want 1", cascade_alert); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (cascade_alert !== 1'b0) begin errors++; $display("FAIL rst_async_alert got %b want 0", cascade_alert); end
        checks++; if (drop_cnt !== 8'd0) begin errors++; $display("FAIL rst_async_drop got %0d want 0", drop_cnt); end
        checks++; if (hist_occ !== 3'd0) begin errors++; $display("FAIL rst_async_occ got %0d want 0", hist_occ); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick();
        send(3'd2, 8'h10);
        send(3'd3, 8'h10);
        checks++; if (cascade_cb_load !== 1'b1 || cascade_type !== 2'd0) begin errors++; $display("FAIL rst_default_table got load %b type %0d want 1 0", cascade_cb_load, cascade_type); end
    endtask

    initial begin
        test_reset();
        test_basic_fire();
        test_multi_pattern();
        test_window();
        test_flush_trigger();
        test_drop();
        test_cfg();
        test_back_to_back();
        test_reset_mid_hold();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
